alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares the single-cycle combinational RISC ALU (4-bit G_sel, 32-bit A/B, C/V/N/Z flags) between two requesters, e.g. the execute stage and an address/branch-compare unit.
- Arbitrates requests using valid/ready handshakes and drives the ALU inputs from registers.
- Captures the result and flags in registers and returns them to the winning requester through a response handshake.

Parameters:
- WIDTH, 32, operand/result width
- SEL_W, 4, ALU function-select width

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_sel  in  SEL_W  requester 0 ALU function
- req0_a  in  WIDTH  requester 0 operand A
- req0_b  in  WIDTH  requester 0 operand B
- req1_valid / req1_ready / req1_sel / req1_a / req1_b  same as requester 0, for requester 1
- rsp0_valid  out  1  result for requester 0 available
- rsp0_ready  in  1  requester 0 consumes result
- rsp1_valid  out  1  result for requester 1 available
- rsp1_ready  in  1  requester 1 consumes result
- rsp_result  out  WIDTH  registered ALU result, shared by both requesters
- rsp_flags  out  4  registered flags {C,V,N,Z}
- alu_g_sel  out  SEL_W  registered drive to ALU G_sel
- alu_a  out  WIDTH  registered drive to ALU A
- alu_b  out  WIDTH  registered drive to ALU B
- alu_out  in  WIDTH  ALU result
- alu_c, alu_v, alu_n, alu_z  in  1 each  ALU flags

Behaviour:
- FSM states: IDLE, EXEC, RESP.
- Reset (rst_n=0 at a clock edge):
  - state=IDLE, last_grant=1, so requester 0 wins the first tie.
  - alu_g_sel/alu_a/alu_b=0, rsp_result=0, rsp_flags=0.
  - rsp0_valid=rsp1_valid=0.
  - req*_ready=0 while rst_n=0.
- Grant (combinational, valid only in IDLE):
  - Only one valid: grant it.
  - Both valid: grant the requester not equal to last_grant (round-robin).
  - None valid: no grant.
- reqN_ready = (state==IDLE) & grantN & rst_n. Ready is never asserted outside IDLE.
- Accept happens at the edge where reqN_valid & reqN_ready:
  - Latch sel/a/b into alu_g_sel/alu_a/alu_b.
  - Record owner=N and set last_grant=N.
  - Go to EXEC.
- EXEC, one cycle, unconditional:
  - Capture alu_out into rsp_result and {alu_c,alu_v,alu_n,alu_z} into rsp_flags.
  - Go to RESP.
- RESP:
  - rsp<owner>_valid=1; the other rsp valid stays 0.
  - rsp_result/rsp_flags held stable while valid.
  - Leave on rsp<owner>_ready=1 at the edge: drop valid, go to IDLE.
  - Stalls indefinitely without ready.
- Latency and throughput:
  - Accept at edge T gives rsp valid from edge T+2.
  - If ready is already high, the next accept is possible at edge T+3, so minimum 3 cycles per op.
- Requesters hold valid and operands stable until ready. Dropping valid before accept is legal and cancels the request.
- alu_g_sel/alu_a/alu_b hold their last value in IDLE and RESP; no gating to zero.
- A request arriving during EXEC/RESP waits and is arbitrated on the next IDLE cycle.
- Reset mid-operation (EXEC or RESP): the operation is discarded, no response is issued, and all outputs return to reset values.
- A result is never issued to the non-owner, even if that requester has its rsp_ready high.

Optional Feature:
- Macro ALU_ARB_FIXED_PRIO_EN.
- Defined: requester 0 always wins when both are valid. last_grant is still updated but ignored.
- Undefined (default): round-robin as above.

Test Plan:
1. Reset check: hold rst_n=0 for 2 cycles with req0_valid=1 -> req0_ready=0, rsp*_valid=0, rsp_result=0, rsp_flags=0, alu_a=0, alu_b=0, alu_g_sel=0.
2. Single op: req0 sel=4'b0000, A=5, B=7, rsp0_ready=1 -> ready at T, alu_a=5 and alu_b=7 after T, rsp0_valid at T+2, rsp_result equals the ALU model output, flags match; next accept no earlier than T+3.
3. Contention, round-robin: both valid continuously, req0 A=25/B=5 sel=4'b0011, req1 A=11/B=101 sel=4'b1100 -> grant order 0,1,0,1 and each result goes only to its owner's rsp valid.
4. Backpressure: rsp1_ready=0 for 5 cycles after rsp1_valid -> rsp1_valid and rsp_result held 5 cycles, req0_ready stays 0, completes on rsp1_ready=1.
5. Reset mid-operation: assert rst_n=0 in EXEC -> no rsp valid ever, state IDLE, req0 wins the next tie.
6. With ALU_ARB_FIXED_PRIO_EN: both valid for 4 ops -> all 4 grants go to requester 0, req1_ready never asserted.

Source files
------------

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Shares one single-cycle combinational ALU between two requesters. A request
// is granted in IDLE, its operands are registered onto the ALU inputs, the ALU
// result and flags are captured one cycle later, and the result is returned to
// the winning requester through a response handshake.
//
// Optional feature macro: ALU_ARB_FIXED_PRIO_EN
//   undefined (default) : round-robin between the two requesters on a tie
//   defined             : requester 0 always wins a tie
//
// Ports
//   clk, rst_n                  clock, synchronous active-low reset
//   req{0,1}_valid/ready        request handshake (ready only in IDLE)
//   req{0,1}_sel/a/b            requested ALU function and operands
//   rsp{0,1}_valid/ready        response handshake, owner only
//   rsp_result, rsp_flags       registered result and {C,V,N,Z}
//   alu_g_sel, alu_a, alu_b     registered drive to the ALU
//   alu_out, alu_c/v/n/z        ALU result and flags
// -----------------------------------------------------------------------------
module alu_arbiter #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SEL_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [SEL_W-1:0] req0_sel,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [SEL_W-1:0] req1_sel,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic [3:0]       rsp_flags,
   output logic [SEL_W-1:0] alu_g_sel,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_c,
   input  logic             alu_v,
   input  logic             alu_n,
   input  logic             alu_z
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next_state;
   logic             r_owner;
   logic             r_last_grant;
   logic [SEL_W-1:0] r_alu_g_sel;
   logic [WIDTH-1:0] r_alu_a;
   logic [WIDTH-1:0] r_alu_b;
   logic [WIDTH-1:0] r_rsp_result;
   logic [3:0]       r_rsp_flags;

   logic             w_grant0;
   logic             w_grant1;
   logic             w_acc0;
   logic             w_acc1;
   logic             w_rsp_done;

   // Grant: only meaningful in IDLE; a tie is broken by the configured policy.
   always_comb begin
      w_grant0 = 1'b0;
      w_grant1 = 1'b0;
      if (r_state == S_IDLE) begin
         if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            // last_grant keeps being tracked but cannot change the outcome
            w_grant0 = 1'b1 | r_last_grant;
`else
            w_grant0 = r_last_grant;
            w_grant1 = ~r_last_grant;
`endif
         end else begin
            w_grant0 = req0_valid;
            w_grant1 = req1_valid;
         end
      end
   end

   assign w_acc0     = req0_valid & w_grant0 & rst_n;
   assign w_acc1     = req1_valid & w_grant1 & rst_n;
   assign w_rsp_done = r_owner ? rsp1_ready : rsp0_ready;

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: if (w_acc0 || w_acc1) w_next_state = S_EXEC;
         S_EXEC: w_next_state = S_RESP;
         S_RESP: if (w_rsp_done) w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // Handshake outputs derived from state and owner.
   always_comb begin
      req0_ready = w_grant0 & rst_n;
      req1_ready = w_grant1 & rst_n;
      rsp0_valid = (r_state == S_RESP) & ~r_owner;
      rsp1_valid = (r_state == S_RESP) & r_owner;
   end

   // Operand capture on accept, result capture in EXEC.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_owner      <= 1'b0;
         r_last_grant <= 1'b1;
         r_alu_g_sel  <= '0;
         r_alu_a      <= '0;
         r_alu_b      <= '0;
         r_rsp_result <= '0;
         r_rsp_flags  <= '0;
      end else begin
         if (w_acc0) begin
            r_alu_g_sel  <= req0_sel;
            r_alu_a      <= req0_a;
            r_alu_b      <= req0_b;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b0;
         end else if (w_acc1) begin
            r_alu_g_sel  <= req1_sel;
            r_alu_a      <= req1_a;
            r_alu_b      <= req1_b;
            r_owner      <= 1'b1;
            r_last_grant <= 1'b1;
         end
         if (r_state == S_EXEC) begin
            r_rsp_result <= alu_out;
            r_rsp_flags  <= {alu_c, alu_v, alu_n, alu_z};
         end
      end
   end

   assign alu_g_sel  = r_alu_g_sel;
   assign alu_a      = r_alu_a;
   assign alu_b      = r_alu_b;
   assign rsp_result = r_rsp_result;
   assign rsp_flags  = r_rsp_flags;

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
// Directed bench for alu_arbiter with a small combinational ALU attached.
// Stimulus pushes expected grants and responses into queues; a monitor on the
// falling edge pops and compares whenever the DUT accepts or responds.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

   logic        clk;
   logic        rst_n;
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [3:0]  req0_sel, req1_sel;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
   logic [31:0] rsp_result;
   logic [3:0]  rsp_flags;
   logic [3:0]  alu_g_sel;
   logic [31:0] alu_a, alu_b, alu_out;
   logic        alu_c, alu_v, alu_n, alu_z;

   alu_arbiter #(.WIDTH(32), .SEL_W(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_sel(req0_sel),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_sel(req1_sel),
      .req1_a(req1_a), .req1_b(req1_b),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
      .rsp_result(rsp_result), .rsp_flags(rsp_flags),
      .alu_g_sel(alu_g_sel), .alu_a(alu_a), .alu_b(alu_b),
      .alu_out(alu_out), .alu_c(alu_c), .alu_v(alu_v), .alu_n(alu_n), .alu_z(alu_z)
   );

   // Attached ALU: 0000 add, 0011 subtract, 1100 and.
   logic [32:0] w_sum;
   always_comb begin
      w_sum   = 33'd0;
      alu_out = 32'd0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (alu_g_sel)
         4'b0000: begin
            w_sum   = {1'b0, alu_a} + {1'b0, alu_b};
            alu_out = w_sum[31:0];
            alu_c   = w_sum[32];
            alu_v   = (alu_a[31] == alu_b[31]) && (w_sum[31] != alu_a[31]);
         end
         4'b0011: begin
            w_sum   = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
            alu_out = w_sum[31:0];
            alu_c   = w_sum[32];
            alu_v   = (alu_a[31] != alu_b[31]) && (w_sum[31] != alu_a[31]);
         end
         4'b1100: alu_out = alu_a & alu_b;
         default: alu_out = 32'd0;
      endcase
      alu_n = alu_out[31];
      alu_z = (alu_out == 32'd0);
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] res;
      logic [3:0]  flg;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   q_grant[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic void push_rsp(input int who, input logic [31:0] r, input logic [3:0] f);
      exp_t e;
      e.res = r;
      e.flg = f;
      if (who == 0) q0.push_back(e);
      else          q1.push_back(e);
   endfunction

   // Monitor: grants and responses are checked against the queues.
   always @(negedge clk) begin
      exp_t e;
      int   g;
      if (rsp0_valid) begin
         chk("rsp0_expected", 32'(q0.size() != 0), 32'd1);
         if (rsp0_ready && q0.size() != 0) begin
            e = q0.pop_front();
            chk("rsp0_result", rsp_result, e.res);
            chk("rsp0_flags", 32'(rsp_flags), 32'(e.flg));
         end
      end
      if (rsp1_valid) begin
         chk("rsp1_expected", 32'(q1.size() != 0), 32'd1);
         if (rsp1_ready && q1.size() != 0) begin
            e = q1.pop_front();
            chk("rsp1_result", rsp_result, e.res);
            chk("rsp1_flags", 32'(rsp_flags), 32'(e.flg));
         end
      end
      if (rsp0_valid || rsp1_valid)
         chk("rsp_single_owner", 32'(rsp0_valid & rsp1_valid), 32'd0);
      if (req0_ready || req1_ready)
         chk("single_ready", 32'(req0_ready & req1_ready), 32'd0);
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
         chk("grant_expected", 32'(q_grant.size() != 0), 32'd1);
         if (q_grant.size() != 0) begin
            g = q_grant.pop_front();
            chk("grant_order", (req1_valid && req1_ready) ? 32'd1 : 32'd0, 32'(g));
         end
      end
   end

   task automatic wait_accept(input int who, input string nm);
      bit got;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         got = (who == 0) ? (req0_valid && req0_ready) : (req1_valid && req1_ready);
      end
      chk(nm, 32'(got), 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic wait_any_accept(input string nm);
      bit got;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         got = (req0_valid && req0_ready) || (req1_valid && req1_ready);
      end
      chk(nm, 32'(got), 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic drain(input string nm);
      for (int i = 0; i < 40 && (q0.size() != 0 || q1.size() != 0); i++)
         @(negedge clk);
      chk(nm, 32'(q0.size() + q1.size()), 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0;
      req0_valid = 1'b0; req0_sel = 4'd0; req0_a = 32'd0; req0_b = 32'd0;
      req1_valid = 1'b0; req1_sel = 4'd0; req1_a = 32'd0; req1_b = 32'd0;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;

      // Reset with a pending request: nothing may be granted or driven.
      req0_valid = 1'b1; req0_sel = 4'b0000; req0_a = 32'd9; req0_b = 32'd9;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk("rst_req0_ready", 32'(req0_ready), 32'd0);
         chk("rst_rsp_valid", 32'({rsp0_valid, rsp1_valid}), 32'd0);
         chk("rst_result", rsp_result, 32'd0);
         chk("rst_flags", 32'(rsp_flags), 32'd0);
         chk("rst_alu_a", alu_a, 32'd0);
         chk("rst_alu_b", alu_b, 32'd0);
         chk("rst_alu_sel", 32'(alu_g_sel), 32'd0);
      end
      @(posedge clk); #1;
      req0_valid = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Contention with both requesters held valid for four operations.
      req0_sel = 4'b0011; req0_a = 32'd25; req0_b = 32'd5;
      req1_sel = 4'b1100; req1_a = 32'd11; req1_b = 32'd101;
      for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
         q_grant.push_back(0);
         push_rsp(0, 32'd20, 4'b1000);
`else
         q_grant.push_back(k % 2);
         if (k % 2 == 0) push_rsp(0, 32'd20, 4'b1000);
         else            push_rsp(1, 32'd1, 4'b0000);
`endif
      end
      req0_valid = 1'b1; req1_valid = 1'b1;
      for (int k = 0; k < 4; k++) wait_any_accept("contention_accept");
      req0_valid = 1'b0; req1_valid = 1'b0;
      drain("contention_drain");

      // Single operation with cycle-exact latency and back-to-back spacing.
      req0_valid = 1'b1; req0_sel = 4'b0000; req0_a = 32'd5; req0_b = 32'd7;
      q_grant.push_back(0);
      push_rsp(0, 32'd12, 4'b0000);
      @(negedge clk);
      chk("single_ready_T", 32'(req0_ready), 32'd1);
      @(posedge clk); #1;
      req0_a = 32'hFFFF_FFFF; req0_b = 32'd1;
      q_grant.push_back(0);
      push_rsp(0, 32'd0, 4'b1001);
      @(negedge clk);
      chk("single_alu_a", alu_a, 32'd5);
      chk("single_alu_b", alu_b, 32'd7);
      chk("single_alu_sel", 32'(alu_g_sel), 32'd0);
      chk("single_exec_rsp0", 32'(rsp0_valid), 32'd0);
      chk("single_exec_ready", 32'(req0_ready), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("single_rsp0_T2", 32'(rsp0_valid), 32'd1);
      chk("single_resp_ready", 32'(req0_ready), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("single_ready_T3", 32'(req0_ready), 32'd1);
      @(posedge clk); #1;
      req0_valid = 1'b0;
      drain("single_drain");

      // Backpressure on requester 1 while requester 0 waits.
      rsp1_ready = 1'b0;
      req1_valid = 1'b1; req1_sel = 4'b0000; req1_a = 32'h7FFF_FFFF; req1_b = 32'd1;
      q_grant.push_back(1);
      push_rsp(1, 32'h8000_0000, 4'b0110);
      wait_accept(1, "bp_req1_accept");
      req1_valid = 1'b0;
      req0_valid = 1'b1; req0_sel = 4'b0011; req0_a = 32'd3; req0_b = 32'd5;
      q_grant.push_back(0);
      push_rsp(0, 32'hFFFF_FFFE, 4'b0010);
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_rsp1_valid", 32'(rsp1_valid), 32'd1);
         chk("bp_rsp0_valid", 32'(rsp0_valid), 32'd0);
         chk("bp_result_held", rsp_result, 32'h8000_0000);
         chk("bp_flags_held", 32'(rsp_flags), 32'd6);
         chk("bp_req0_ready", 32'(req0_ready), 32'd0);
         @(posedge clk); #1;
      end
      rsp1_ready = 1'b1;
      wait_accept(0, "bp_req0_accept");
      req0_valid = 1'b0;
      drain("bp_drain");

      // Reset while an operation is in EXEC: it is discarded.
      req0_valid = 1'b1; req0_sel = 4'b0000; req0_a = 32'd1; req0_b = 32'd2;
      q_grant.push_back(0);
      wait_accept(0, "mid_rst_accept");
      req0_valid = 1'b0;
      rst_n = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("mid_rst_rsp_valid", 32'({rsp0_valid, rsp1_valid}), 32'd0);
      chk("mid_rst_result", rsp_result, 32'd0);
      chk("mid_rst_alu_a", alu_a, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("post_rst_no_rsp", 32'({rsp0_valid, rsp1_valid}), 32'd0);
         @(posedge clk); #1;
      end
      req0_sel = 4'b1100; req0_a = 32'hF0F0_F0F0; req0_b = 32'hFF00_FF00;
      req1_sel = 4'b0011; req1_a = 32'd7; req1_b = 32'd7;
      q_grant.push_back(0);
      push_rsp(0, 32'hF000_F000, 4'b0010);
`ifdef ALU_ARB_FIXED_PRIO_EN
      q_grant.push_back(0);
      push_rsp(0, 32'hF000_F000, 4'b0010);
`else
      q_grant.push_back(1);
      push_rsp(1, 32'd0, 4'b1001);
`endif
      req0_valid = 1'b1; req1_valid = 1'b1;
      for (int k = 0; k < 2; k++) wait_any_accept("post_rst_accept");
      req0_valid = 1'b0; req1_valid = 1'b0;
      drain("post_rst_drain");

      chk("grants_consumed", 32'(q_grant.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
